// File: rtl/systolic_array_integration.sv
// Output-stationary MxM systolic matrix multiplier with per-row/column input FIFOs.
// A start pulse drains M words per FIFO, skewed diagonally, into the MAC grid; done pulses at the end.
module systolic_array_integration #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned M          = 3,
  parameter int unsigned COUNT_MAX  = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [M-1:0]                           s_valid_w,
  output logic [M-1:0]                           s_ready_w,
  input  logic [M-1:0][DATA_WIDTH-1:0]           s_data_w,
  input  logic [M-1:0]                           s_valid_a,
  output logic [M-1:0]                           s_ready_a,
  input  logic [M-1:0][DATA_WIDTH-1:0]           s_data_a,
  output logic [M-1:0][M-1:0][DATA_WIDTH-1:0]    result_out,
  output logic                                   done
);

  localparam int unsigned CNT_W = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             done_nxt;
  logic             clear_c;
  logic             run_c;

  // Control FSM: IDLE waits for start, RUN sweeps cnt through the skewed schedule
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    clear_c   = 1'b0;
    run_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
          clear_c   = 1'b1;
        end
      end
      ST_RUN: begin
        run_c = 1'b1;
        if (cnt == CNT_W'(COUNT_MAX - 1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  // Operand index 0 = activations (rows), 1 = weights (columns)
  logic [1:0][M-1:0]                 in_valid;
  logic [1:0][M-1:0][DATA_WIDTH-1:0] in_data;
  logic [1:0][M-1:0]                 not_full;
  logic [1:0][M-1:0]                 not_empty;
  logic [1:0][M-1:0]                 push;
  logic [1:0][M-1:0]                 pop;
  logic [1:0][M-1:0]                 win;
  logic [1:0][M-1:0][DATA_WIDTH-1:0] head;
  logic [1:0][M-1:0][DATA_WIDTH-1:0] feed;

  assign in_valid  = {s_valid_w, s_valid_a};
  assign in_data   = {s_data_w, s_data_a};
  assign s_ready_a = not_full[0];
  assign s_ready_w = not_full[1];

  for (genvar op = 0; op < 2; op++) begin : g_op
    for (genvar k = 0; k < M; k++) begin : g_fifo
      localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(k);
      localparam logic [CNT_W-1:0] WIN_HI = CNT_W'(k + M - 1);

      logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0]      wr_ptr, rd_ptr;
      logic [LVL_W-1:0]      level;

      assign not_full[op][k]  = (level != LVL_W'(FIFO_DEPTH));
      assign not_empty[op][k] = (level != '0);
      assign push[op][k]      = in_valid[op][k] & not_full[op][k];

      // Feed window for lane k opens k cycles into RUN and lasts M cycles
      if (k == 0) begin : g_win0
        assign win[op][k] = run_c && (cnt <= WIN_HI);
      end else begin : g_winn
        assign win[op][k] = run_c && (cnt >= WIN_LO) && (cnt <= WIN_HI);
      end

      assign pop[op][k]  = win[op][k] & not_empty[op][k];
      assign head[op][k] = mem[rd_ptr];
      assign feed[op][k] = pop[op][k] ? head[op][k] : '0;

      always_ff @(posedge clk) begin
        if (push[op][k]) mem[wr_ptr] <= in_data[op][k];
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          level  <= '0;
        end else begin
          if (push[op][k])
            wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
          if (pop[op][k])
            rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
          case ({push[op][k], pop[op][k]})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
          endcase
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] a_pipe [M][M];
  logic [DATA_WIDTH-1:0] w_pipe [M][M];
  logic [DATA_WIDTH-1:0] a_in   [M][M];
  logic [DATA_WIDTH-1:0] w_in   [M][M];

  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < M; j++) begin : g_col
      logic [DATA_WIDTH-1:0] a_q, w_q, acc_q;

      if (j == 0) begin : g_a_edge
        assign a_in[i][j] = feed[0][i];
      end else begin : g_a_int
        assign a_in[i][j] = a_pipe[i][j-1];
      end
      if (i == 0) begin : g_w_edge
        assign w_in[i][j] = feed[1][j];
      end else begin : g_w_int
        assign w_in[i][j] = w_pipe[i-1][j];
      end

      // PE: forward a right and w down, accumulate modulo 2^DATA_WIDTH
      always_ff @(posedge clk) begin
        if (!reset || clear_c) begin
          a_q   <= '0;
          w_q   <= '0;
          acc_q <= '0;
        end else if (run_c) begin
          a_q   <= a_in[i][j];
          w_q   <= w_in[i][j];
          acc_q <= acc_q + a_in[i][j] * w_in[i][j];
        end
      end

      assign a_pipe[i][j]     = a_q;
      assign w_pipe[i][j]     = w_q;
      assign result_out[i][j] = acc_q;
    end
  end

endmodule

// File: tb/tb_systolic_array_integration.sv
// Directed self-checking bench for systolic_array_integration (3x3, 32-bit, depth-4 FIFOs).
module tb_systolic_array_integration;

  localparam int unsigned DW    = 32;
  localparam int unsigned M     = 3;
  localparam int unsigned CMAX  = 10;
  localparam int unsigned DEPTH = 4;

  logic                         clk = 1'b0;
  logic                         reset = 1'b0;
  logic                         start = 1'b0;
  logic [M-1:0]                 s_valid_w = '0;
  logic [M-1:0]                 s_ready_w;
  logic [M-1:0][DW-1:0]         s_data_w = '0;
  logic [M-1:0]                 s_valid_a = '0;
  logic [M-1:0]                 s_ready_a;
  logic [M-1:0][DW-1:0]         s_data_a = '0;
  logic [M-1:0][M-1:0][DW-1:0]  result_out;
  logic                         done;

  int n_tests = 0;
  int n_fail  = 0;

  systolic_array_integration #(
    .DATA_WIDTH(DW), .M(M), .COUNT_MAX(CMAX), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .s_valid_w(s_valid_w), .s_ready_w(s_ready_w), .s_data_w(s_data_w),
    .s_valid_a(s_valid_a), .s_ready_a(s_ready_a), .s_data_a(s_data_a),
    .result_out(result_out), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [M-1:0][DW-1:0] mk3(input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                                               input logic [DW-1:0] x2);
    mk3[0] = x0;
    mk3[1] = x1;
    mk3[2] = x2;
  endfunction

  // One push cycle; called and returns at 1 time unit after a rising edge
  task automatic push(input logic [M-1:0] vw, input logic [M-1:0][DW-1:0] dw,
                      input logic [M-1:0] va, input logic [M-1:0][DW-1:0] da);
    s_valid_w = vw; s_data_w = dw;
    s_valid_a = va; s_data_a = da;
    @(posedge clk); #1;
    s_valid_w = '0; s_valid_a = '0;
  endtask

  task automatic load_basic();
    push(3'b111, mk3(1, 2, 3), 3'b111, mk3(1, 2, 3));
    push(3'b111, mk3(4, 5, 6), 3'b111, mk3(4, 5, 6));
    push(3'b111, mk3(7, 8, 9), 3'b111, mk3(7, 8, 9));
  endtask

  task automatic load_a_identity();
    for (int k = 0; k < M; k++) begin
      logic [M-1:0][DW-1:0] da;
      for (int i = 0; i < M; i++) da[i] = (i == k) ? DW'(1) : DW'(0);
      push(3'b000, '0, 3'b111, da);
    end
  endtask

  // Returns edges from the start-capture edge until done is seen, or -1 on timeout
  task automatic run_start(input bit hold, output int lat);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done got %0b expected 0", done);
    end
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        n_tests++;
        if (result_out[i][j] !== '0) begin
          n_fail++; $display("FAIL reset_result[%0d][%0d] got %0d expected 0", i, j, result_out[i][j]);
        end
      end
    reset = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({s_ready_w, s_ready_a} !== 6'b111111) begin
      n_fail++; $display("FAIL reset_ready got w=%b a=%b expected 111/111", s_ready_w, s_ready_a);
    end
  endtask

  task automatic test_basic();
    int unsigned exp_c [M][M] = '{'{66, 78, 90}, '{78, 93, 108}, '{90, 108, 126}};
    int lat;
    load_basic();
    run_start(1'b0, lat);
    n_tests++;
    if (lat != int'(CMAX)) begin
      n_fail++; $display("FAIL basic_latency got %0d expected %0d", lat, CMAX);
    end
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        n_tests++;
        if (result_out[i][j] !== DW'(exp_c[i][j])) begin
          n_fail++; $display("FAIL basic_C[%0d][%0d] got %0d expected %0d", i, j, result_out[i][j], exp_c[i][j]);
        end
      end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_width got %0b expected 0", done);
    end
    n_tests++;
    if (result_out[1][1] !== DW'(93)) begin
      n_fail++; $display("FAIL basic_hold got %0d expected 93", result_out[1][1]);
    end
  endtask

  task automatic test_identity();
    int lat;
    for (int k = 0; k < M; k++) begin
      logic [M-1:0][DW-1:0] dw, da;
      for (int j = 0; j < M; j++) dw[j] = (j == k) ? DW'(1) : DW'(0);
      for (int i = 0; i < M; i++) da[i] = DW'(3 * i + k + 1);
      push(3'b111, dw, 3'b111, da);
    end
    run_start(1'b0, lat);
    n_tests++;
    if (lat != int'(CMAX)) begin
      n_fail++; $display("FAIL identity_latency got %0d expected %0d", lat, CMAX);
    end
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        n_tests++;
        if (result_out[i][j] !== DW'(3 * i + j + 1)) begin
          n_fail++; $display("FAIL identity_C[%0d][%0d] got %0d expected %0d", i, j, result_out[i][j], 3 * i + j + 1);
        end
      end
  endtask

  task automatic test_full();
    int lat;
    for (int k = 1; k <= int'(DEPTH); k++) push(3'b001, mk3(DW'(k), 0, 0), 3'b000, '0);
    n_tests++;
    if (s_ready_w !== 3'b110) begin
      n_fail++; $display("FAIL full_ready got %b expected 110", s_ready_w);
    end
    push(3'b001, mk3(5, 0, 0), 3'b000, '0);
    n_tests++;
    if (s_ready_w[0] !== 1'b0) begin
      n_fail++; $display("FAIL full_ready_after_drop got %b expected 0", s_ready_w[0]);
    end
    load_a_identity();
    run_start(1'b0, lat);
    n_tests++;
    if (lat != int'(CMAX)) begin
      n_fail++; $display("FAIL full_latency got %0d expected %0d", lat, CMAX);
    end
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        logic [DW-1:0] e;
        e = (j == 0) ? DW'(i + 1) : DW'(0);
        n_tests++;
        if (result_out[i][j] !== e) begin
          n_fail++; $display("FAIL full_run1_C[%0d][%0d] got %0d expected %0d", i, j, result_out[i][j], e);
        end
      end
    n_tests++;
    if (s_ready_w[0] !== 1'b1) begin
      n_fail++; $display("FAIL full_ready_after_run got %b expected 1", s_ready_w[0]);
    end
    // Only the surplus 4th word remains; the dropped 5th must not appear
    load_a_identity();
    run_start(1'b0, lat);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        logic [DW-1:0] e;
        e = (i == 0 && j == 0) ? DW'(4) : DW'(0);
        n_tests++;
        if (result_out[i][j] !== e) begin
          n_fail++; $display("FAIL full_run2_C[%0d][%0d] got %0d expected %0d", i, j, result_out[i][j], e);
        end
      end
  endtask

  task automatic test_back_to_back();
    int lat;
    int extra;
    load_basic();
    run_start(1'b1, lat);
    n_tests++;
    if (lat != int'(CMAX)) begin
      n_fail++; $display("FAIL held_latency got %0d expected %0d", lat, CMAX);
    end
    n_tests++;
    if (result_out[2][2] !== DW'(126) || result_out[0][1] !== DW'(78)) begin
      n_fail++; $display("FAIL held_result got %0d/%0d expected 126/78", result_out[2][2], result_out[0][1]);
    end
    extra = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    n_tests++;
    if (extra != 0) begin
      n_fail++; $display("FAIL held_extra_done got %0d expected 0", extra);
    end
    run_start(1'b0, lat);
    n_tests++;
    if (lat != int'(CMAX)) begin
      n_fail++; $display("FAIL empty_latency got %0d expected %0d", lat, CMAX);
    end
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        n_tests++;
        if (result_out[i][j] !== '0) begin
          n_fail++; $display("FAIL empty_C[%0d][%0d] got %0d expected 0", i, j, result_out[i][j]);
        end
      end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen;
    load_basic();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    n_tests++;
    if (result_out[0][0] !== '0 || result_out[1][0] !== '0) begin
      n_fail++; $display("FAIL midreset_clear got %0d/%0d expected 0/0", result_out[0][0], result_out[1][0]);
    end
    n_tests++;
    if ({s_ready_w, s_ready_a} !== 6'b111111) begin
      n_fail++; $display("FAIL midreset_ready got w=%b a=%b expected 111/111", s_ready_w, s_ready_a);
    end
    seen = 0;
    repeat (15) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL midreset_done got %0d pulses expected 0", seen);
    end
    load_basic();
    run_start(1'b0, lat);
    n_tests++;
    if (lat != int'(CMAX)) begin
      n_fail++; $display("FAIL midreset_latency got %0d expected %0d", lat, CMAX);
    end
    n_tests++;
    if (result_out[0][0] !== DW'(66) || result_out[2][1] !== DW'(108) || result_out[1][2] !== DW'(108)) begin
      n_fail++; $display("FAIL midreset_rerun got %0d/%0d/%0d expected 66/108/108",
                         result_out[0][0], result_out[2][1], result_out[1][2]);
    end
  endtask

  task automatic test_overflow();
    int lat;
    repeat (3) push(3'b001, mk3(32'hFFFF_FFFF, 0, 0), 3'b001, mk3(32'hFFFF_FFFF, 0, 0));
    run_start(1'b0, lat);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        logic [DW-1:0] e;
        e = (i == 0 && j == 0) ? DW'(3) : DW'(0);
        n_tests++;
        if (result_out[i][j] !== e) begin
          n_fail++; $display("FAIL overflow_C[%0d][%0d] got %0d expected %0d", i, j, result_out[i][j], e);
        end
      end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_identity();
    test_full();
    test_back_to_back();
    test_reset_mid_run();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
